// File: rtl/nios_io_pkg.sv
// ---------------------------------------------------------------------------
// nios_io_pkg
//   Shared constants and helpers for the Nios board-I/O conditioning blocks.
//
//   DEFAULT_DEBOUNCE_CYCLES : default settle time in clocks (1 ms at 50 MHz)
//   SYS_CLK_HZ              : Nios system clock frequency
//   cnt_width()             : width of a settle counter for a given cycle count
// ---------------------------------------------------------------------------
package nios_io_pkg;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
   localparam int SYS_CLK_HZ              = 50_000_000;

   // One spare bit above clog2 keeps DEBOUNCE_CYCLES=1 at a legal 1-bit width
   // and leaves headroom for exact powers of two.
   function automatic int cnt_width(input int cycles);
      return $clog2(cycles) + 1;
   endfunction

endpackage

// File: rtl/nios_debounce_bit.sv
// ---------------------------------------------------------------------------
// nios_debounce_bit
//   One switch/key channel: 2-flop synchronizer, optional inversion, settle
//   counter and registered debounced level with one-cycle rise/fall strobes.
//
//   Ports:
//     clk     in   system clock
//     reset   in   synchronous active-high reset
//     raw     in   asynchronous pin
//     level   out  debounced, polarity-corrected level
//     rise    out  registered 1-cycle strobe, level went 0->1
//     fall    out  registered 1-cycle strobe, level went 1->0
//     accept  out  combinational: level changes on the coming edge
// ---------------------------------------------------------------------------
module nios_debounce_bit
   import nios_io_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter logic INVERT          = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall,
   output logic accept
);

   localparam int              CNT_W   = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_reg;
   logic             sync2_reg;
   logic             lvl;
   logic [CNT_W-1:0] cnt_reg,   cnt_next;
   logic             level_reg, level_next;
   logic             rise_reg,  rise_next;
   logic             fall_reg,  fall_next;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
         cnt_reg   <= '0;
         level_reg <= 1'b0;
         rise_reg  <= 1'b0;
         fall_reg  <= 1'b0;
      end else begin
         sync1_reg <= raw;
         sync2_reg <= sync1_reg;
         cnt_reg   <= cnt_next;
         level_reg <= level_next;
         rise_reg  <= rise_next;
         fall_reg  <= fall_next;
      end
   end

   // Next state: cnt==0 with lvl==level is the stable state; any nonzero
   // count means a new level is settling. A bounce back to the current level
   // clears the count, so only an unbroken run is ever accepted.
   always_comb begin
      lvl        = sync2_reg ^ INVERT;
      cnt_next   = '0;
      level_next = level_reg;
      rise_next  = 1'b0;
      fall_next  = 1'b0;
      if (lvl != level_reg) begin
         if (cnt_reg == CNT_MAX) begin
            level_next = lvl;
            rise_next  = lvl;
            fall_next  = ~lvl;
         end else begin
            cnt_next = cnt_reg + CNT_W'(1);
         end
      end
   end

   assign level  = level_reg;
   assign rise   = rise_reg;
   assign fall   = fall_reg;
   assign accept = rise_next | fall_next;

endmodule

// File: rtl/nios_sw_debounce.sv
// ---------------------------------------------------------------------------
// nios_sw_debounce
//   Conditions raw board switches/keys for the Avalon PIO in_port: per-bit
//   synchronization, polarity correction and debouncing, plus edge strobes
//   for a later edge-capture/IRQ stage.
//
//   Ports:
//     clk       in   system clock
//     reset     in   synchronous active-high reset
//     raw_in    in   [WIDTH] asynchronous switch/key pins
//     data_out  out  [WIDTH] debounced level, drives PIO in_port
//     rise      out  [WIDTH] 1-cycle strobe per bit, 0->1
//     fall      out  [WIDTH] 1-cycle strobe per bit, 1->0
//     changed   out  OR of rise|fall, same cycle
// ---------------------------------------------------------------------------
module nios_sw_debounce
   import nios_io_pkg::*;
#(
   parameter int               WIDTH           = 8,
   parameter int               DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter logic [WIDTH-1:0] INVERT_MASK     = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] raw_in,
   output logic [WIDTH-1:0] data_out,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             changed
);

   logic [WIDTH-1:0] accept;
   logic             changed_reg;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         nios_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .INVERT          (INVERT_MASK[gi])
         ) u_bit (
            .clk    (clk),
            .reset  (reset),
            .raw    (raw_in[gi]),
            .level  (data_out[gi]),
            .rise   (rise[gi]),
            .fall   (fall[gi]),
            .accept (accept[gi])
         );
      end
   endgenerate

   // Registered from the per-bit next-strobe terms so it lands on the same
   // edge as rise/fall; several bits accepting together still give one pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         changed_reg <= 1'b0;
      end else begin
         changed_reg <= |accept;
      end
   end

   assign changed = changed_reg;

endmodule

// File: tb/tb_nios_sw_debounce.sv
module tb_nios_sw_debounce;

   logic       clk;
   logic       reset;
   logic [7:0] raw_in;
   logic [7:0] data_out;
   logic [7:0] rise;
   logic [7:0] fall;
   logic       changed;

   int   n_checks;
   int   n_errors;
   logic [7:0] exp_do;

   nios_sw_debounce #(
      .WIDTH           (8),
      .DEBOUNCE_CYCLES (4),
      .INVERT_MASK     (8'h0F)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .raw_in   (raw_in),
      .data_out (data_out),
      .rise     (rise),
      .fall     (fall),
      .changed  (changed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge; outputs are sampled 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, ".data"},    {24'h0, data_out}, {24'h0, exp_do});
      chk({tag, ".rise"},    {24'h0, rise},     32'h0);
      chk({tag, ".fall"},    {24'h0, fall},     32'h0);
      chk({tag, ".changed"}, {31'h0, changed},  32'h0);
   endtask

   // Expect data_out to change on the n-th edge from now (raw already set),
   // with no activity before it and strobes cleared one edge later.
   task automatic expect_edge(input int n, input logic [7:0] new_do,
                              input logic [7:0] exp_rise, input logic [7:0] exp_fall,
                              input string tag);
      for (int k = 1; k < n; k++) begin
         step();
         chk_quiet({tag, ".pre"});
      end
      step();
      chk({tag, ".data"},    {24'h0, data_out}, {24'h0, new_do});
      chk({tag, ".rise"},    {24'h0, rise},     {24'h0, exp_rise});
      chk({tag, ".fall"},    {24'h0, fall},     {24'h0, exp_fall});
      chk({tag, ".changed"}, {31'h0, changed},  {31'h0, ((exp_rise | exp_fall) != 8'h00)});
      exp_do = new_do;
      step();
      chk_quiet({tag, ".post"});
      $display("txn %s data_out=%h rise=%h fall=%h", tag, new_do, exp_rise, exp_fall);
   endtask

   initial begin
      int pat[7];
      pat      = '{1, 1, 0, 1, 1, 1, 1};
      n_checks = 0;
      n_errors = 0;
      exp_do   = 8'h00;
      reset    = 1'b1;
      raw_in   = 8'h0F;

      // Reset hold, then 20 quiet cycles (inverted bits idle high -> 0)
      for (int k = 0; k < 3; k++) begin
         step();
         chk_quiet("reset_hold");
      end
      reset = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step();
         chk_quiet("after_reset");
      end
      $display("txn reset_hold data_out=%h", data_out);

      // Clean step on bit 7 and its return
      raw_in = 8'h8F;
      expect_edge(6, 8'h80, 8'h80, 8'h00, "clean_rise");
      raw_in = 8'h0F;
      expect_edge(6, 8'h00, 8'h00, 8'h80, "clean_fall");

      // Glitch: bit 4 high for 3 cycles only
      raw_in = 8'h1F;
      for (int k = 0; k < 3; k++) begin
         step();
         chk_quiet("glitch_hi");
      end
      raw_in = 8'h0F;
      for (int k = 0; k < 10; k++) begin
         step();
         chk_quiet("glitch_lo");
      end
      $display("txn glitch data_out=%h", data_out);

      // Bounce on bit 5: restart at the 0, accept on edge 9
      for (int k = 0; k < 7; k++) begin
         raw_in[5] = pat[k][0];
         step();
         chk_quiet("bounce_pre");
      end
      expect_edge(2, 8'h20, 8'h20, 8'h00, "bounce_rise");
      raw_in = 8'h0F;
      expect_edge(6, 8'h00, 8'h00, 8'h20, "bounce_fall");

      // Active-low key on bit 0
      raw_in = 8'h0E;
      expect_edge(6, 8'h01, 8'h01, 8'h00, "key_press");
      raw_in = 8'h0F;
      expect_edge(6, 8'h00, 8'h00, 8'h01, "key_release");

      // Simultaneous bits 7 and 6
      raw_in = 8'hCF;
      expect_edge(6, 8'hC0, 8'hC0, 8'h00, "simul_rise");
      raw_in = 8'h0F;
      expect_edge(6, 8'h00, 8'h00, 8'hC0, "simul_fall");

      // Same, with reset pulsed mid-settle (count 2): settling restarts
      raw_in = 8'hCF;
      for (int k = 0; k < 4; k++) begin
         step();
         chk_quiet("rst_mid_pre");
      end
      reset = 1'b1;
      step();
      chk_quiet("rst_mid_pulse");
      reset = 1'b0;
      expect_edge(6, 8'hC0, 8'hC0, 8'h00, "rst_mid_rise");

      // Reset clears an accepted level; held-high bits come back with a rise
      reset = 1'b1;
      step();
      exp_do = 8'h00;
      chk_quiet("rst_clear");
      reset = 1'b0;
      expect_edge(6, 8'hC0, 8'hC0, 8'h00, "rst_reacquire");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
